// File: rtl/ysyx_wbq_pkg.sv
// Shared types for the write-back/retire queue: the queued entry layout
// and the register-file write predicate.
package ysyx_wbq_pkg;

    localparam int WBQ_XLEN  = 32;
    localparam int WBQ_RF_AW = 5;

    typedef struct packed {
        logic [WBQ_XLEN-1:0]  pc;
        logic [WBQ_XLEN-1:0]  inst;
        logic [WBQ_RF_AW-1:0] rd;
        logic [WBQ_XLEN-1:0]  wdata;
        logic                 rwen;
        logic                 ebreak;
    } wbq_entry_t;

    localparam int WBQ_ENTRY_W = $bits(wbq_entry_t);

    // x0 is hardwired to zero, so writes to it are suppressed.
    function automatic logic rf_we_pred(input wbq_entry_t e);
        return e.rwen && (e.rd != '0);
    endfunction

endpackage

// File: rtl/ysyx_wbq_fifo.sv
// Generic DEPTH-entry circular buffer with push/pop/clear and occupancy.
// DEPTH must be a power of two so the pointers wrap naturally.
module ysyx_wbq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic                         clear_i,
    input  logic [W-1:0]                 data_i,
    output logic [W-1:0]                 data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) tail_d = tail_q + PW'(1);
            if (pop_i)  head_d = head_q + PW'(1);
            count_d = count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) mem_q[tail_q] <= data_i;
    end

    assign data_o  = mem_q[head_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/ysyx_wbq.sv
// Write-back/retire queue: buffers completed instructions and retires them
// in order toward the register file, with flush, ebreak halt and retire count.
module ysyx_wbq
    import ysyx_wbq_pkg::*;
#(
    parameter int XLEN  = WBQ_XLEN,
    parameter int DEPTH = 4,
    parameter int RF_AW = WBQ_RF_AW
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       prev_valid,
    output logic                       ready_o,
    input  logic [XLEN-1:0]            pc,
    input  logic [XLEN-1:0]            inst,
    input  logic [RF_AW-1:0]           rd,
    input  logic [XLEN-1:0]            wdata,
    input  logic                       rwen,
    input  logic                       ebreak,
    output logic                       valid_o,
    input  logic                       next_ready,
    output logic [XLEN-1:0]            pc_o,
    output logic [XLEN-1:0]            inst_o,
    output logic                       rf_we,
    output logic [RF_AW-1:0]           rf_waddr,
    output logic [XLEN-1:0]            rf_wdata,
    input  logic                       flush,
    output logic                       halt_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic [63:0]                retire_cnt
);

    wbq_entry_t in_entry;
    wbq_entry_t head;
    logic       full, empty;
    logic       push, retire, clear;
    logic       ebreak_fire;
    logic       halt_q, halt_d;
    logic [63:0] retire_cnt_q, retire_cnt_d;

    always_comb begin
        in_entry        = '0;
        in_entry.pc     = pc;
        in_entry.inst   = inst;
        in_entry.rd     = rd;
        in_entry.wdata  = wdata;
        in_entry.rwen   = rwen;
        in_entry.ebreak = ebreak;
    end

    assign valid_o = !empty && !halt_q;
    assign ready_o = !full && !halt_q;
    assign retire  = valid_o && next_ready;

    // Hook point for the simulator's ebreak handler; high for exactly one cycle.
    assign ebreak_fire = retire && head.ebreak;

    // Flush and halt both drop the rest of the queue and any incoming entry.
    assign clear = flush || ebreak_fire;
    assign push  = prev_valid && ready_o && !clear;

    ysyx_wbq_fifo #(
        .DEPTH (DEPTH),
        .W     (WBQ_ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (retire),
        .clear_i (clear),
        .data_i  (in_entry),
        .data_o  (head),
        .count_o (count_o),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        halt_d       = halt_q || ebreak_fire;
        retire_cnt_d = retire_cnt_q + (retire ? 64'd1 : 64'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            halt_q       <= 1'b0;
            retire_cnt_q <= '0;
        end else begin
            halt_q       <= halt_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign pc_o       = head.pc;
    assign inst_o     = head.inst;
    assign rf_we      = retire && rf_we_pred(head);
    assign rf_waddr   = head.rd;
    assign rf_wdata   = head.wdata;
    assign halt_o     = halt_q;
    assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_ysyx_wbq.sv
// Directed self-checking bench for ysyx_wbq: reset, single retire, fill and
// backpressure, pointer wrap, x0 write, flush and ebreak halt.
module tb_ysyx_wbq;

    logic        clk = 1'b0;
    logic        rst;
    logic        prevValid;
    logic        readyO;
    logic [31:0] pcIn, instIn, wdataIn;
    logic [4:0]  rdIn;
    logic        rwenIn, ebreakIn;
    logic        validO;
    logic        nextReady;
    logic [31:0] pcO, instO, rfWdata;
    logic        rfWe;
    logic [4:0]  rfWaddr;
    logic        flushIn;
    logic        haltO;
    logic [2:0]  countO;
    logic [63:0] retireCnt;

    int nChecks = 0;
    int nFails  = 0;
    int hookCnt = 0;

    always #5 clk = ~clk;

    ysyx_wbq #(.XLEN(32), .DEPTH(4), .RF_AW(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .prev_valid (prevValid),
        .ready_o    (readyO),
        .pc         (pcIn),
        .inst       (instIn),
        .rd         (rdIn),
        .wdata      (wdataIn),
        .rwen       (rwenIn),
        .ebreak     (ebreakIn),
        .valid_o    (validO),
        .next_ready (nextReady),
        .pc_o       (pcO),
        .inst_o     (instO),
        .rf_we      (rfWe),
        .rf_waddr   (rfWaddr),
        .rf_wdata   (rfWdata),
        .flush      (flushIn),
        .halt_o     (haltO),
        .count_o    (countO),
        .retire_cnt (retireCnt)
    );

    // Counts invocations of the simulation ebreak hook.
    always @(posedge clk) begin
        if (dut.ebreak_fire) hookCnt++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic pv, input logic [31:0] p, input logic [31:0] ins,
                                 input logic [4:0] r, input logic [31:0] wd,
                                 input logic we, input logic eb);
        prevValid = pv;
        pcIn      = p;
        instIn    = ins;
        rdIn      = r;
        wdataIn   = wd;
        rwenIn    = we;
        ebreakIn  = eb;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic expReady;
        rst = 1'b1; nextReady = 1'b0; flushIn = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0);
        tick(); tick();
        rst = 1'b0;
        nextReady = 1'b1;
        #1;
        checkOutput("rst_count", 64'(countO), 64'd0);
        checkOutput("rst_valid", 64'(validO), 64'd0);
        checkOutput("rst_ready", 64'(readyO), 64'd1);
        checkOutput("rst_halt", 64'(haltO), 64'd0);
        checkOutput("rst_retire_cnt", retireCnt, 64'd0);
        checkOutput("rst_rf_we", 64'(rfWe), 64'd0);

        // Single entry
        applyStimulus(1'b1, 32'h8000_0000, 32'h0000_0013, 5'd5, 32'h1234, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0);
        checkOutput("single_valid", 64'(validO), 64'd1);
        checkOutput("single_pc", 64'(pcO), 64'h8000_0000);
        checkOutput("single_inst", 64'(instO), 64'h13);
        checkOutput("single_rf_we", 64'(rfWe), 64'd1);
        checkOutput("single_waddr", 64'(rfWaddr), 64'd5);
        checkOutput("single_wdata", 64'(rfWdata), 64'h1234);
        tick();
        checkOutput("single_retire_cnt", retireCnt, 64'd1);
        checkOutput("single_count", 64'(countO), 64'd0);
        checkOutput("single_valid_after", 64'(validO), 64'd0);

        // Fill and backpressure
        nextReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 32'(i * 4), 32'h0, 5'(i + 1), 32'(i), 1'b1, 1'b0);
            expReady = (i < 4);
            checkOutput($sformatf("fill_ready_%0d", i), 64'(readyO), 64'(expReady));
            tick();
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0);
        checkOutput("fill_count", 64'(countO), 64'd4);
        checkOutput("fill_ready_full", 64'(readyO), 64'd0);
        nextReady = 1'b1;
        #1;
        checkOutput("fill_head_pc0", 64'(pcO), 64'd0);
        checkOutput("fill_ready_pop_cycle", 64'(readyO), 64'd0);
        tick();
        checkOutput("fill_ready_after_pop", 64'(readyO), 64'd1);
        checkOutput("fill_count_3", 64'(countO), 64'd3);
        checkOutput("fill_head_pc4", 64'(pcO), 64'd4);
        tick();
        checkOutput("fill_head_pc8", 64'(pcO), 64'd8);
        tick();
        checkOutput("fill_head_pc12", 64'(pcO), 64'd12);
        checkOutput("fill_rd_last", 64'(rfWaddr), 64'd4);
        tick();
        checkOutput("fill_drained", 64'(countO), 64'd0);
        checkOutput("fill_retire_cnt", retireCnt, 64'd5);

        // Wrap-around streaming
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 32'h100 + 32'(4 * k), 32'h0, 5'd1, 32'(k), 1'b1, 1'b0);
            if (k > 0) begin
                checkOutput($sformatf("wrap_pc_%0d", k), 64'(pcO), 64'(32'h100 + 32'(4 * (k - 1))));
                checkOutput($sformatf("wrap_count_%0d", k), 64'(countO), 64'd1);
            end
            tick();
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0);
        checkOutput("wrap_pc_last", 64'(pcO), 64'h124);
        tick();
        checkOutput("wrap_drained", 64'(countO), 64'd0);
        checkOutput("wrap_retire_cnt", retireCnt, 64'd15);

        // Write to x0 is suppressed but still retires
        nextReady = 1'b0;
        applyStimulus(1'b1, 32'h180, 32'h0, 5'd0, 32'hdead, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0);
        nextReady = 1'b1;
        #1;
        checkOutput("x0_valid", 64'(validO), 64'd1);
        checkOutput("x0_rf_we", 64'(rfWe), 64'd0);
        tick();
        checkOutput("x0_retire_cnt", retireCnt, 64'd16);

        // Flush with a retire and a push in the same cycle
        nextReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h200 + 32'(4 * i), 32'h0, 5'd7, 32'h55, 1'b1, 1'b0);
            tick();
        end
        applyStimulus(1'b1, 32'h20c, 32'h0, 5'd9, 32'h99, 1'b1, 1'b0);
        flushIn = 1'b1;
        nextReady = 1'b1;
        #1;
        checkOutput("flush_rf_we", 64'(rfWe), 64'd1);
        checkOutput("flush_waddr", 64'(rfWaddr), 64'd7);
        checkOutput("flush_pc", 64'(pcO), 64'h200);
        tick();
        flushIn = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0);
        checkOutput("flush_count", 64'(countO), 64'd0);
        checkOutput("flush_valid", 64'(validO), 64'd0);
        checkOutput("flush_ready", 64'(readyO), 64'd1);
        checkOutput("flush_retire_cnt", retireCnt, 64'd17);

        // Ebreak halt
        rst = 1'b1;
        tick();
        rst = 1'b0;
        nextReady = 1'b0;
        applyStimulus(1'b1, 32'h300, 32'h0000_0033, 5'd3, 32'h1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h304, 32'h0010_0073, 5'd0, 32'h0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 32'h308, 32'h0000_0033, 5'd4, 32'h2, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0);
        checkOutput("eb_count_3", 64'(countO), 64'd3);
        nextReady = 1'b1;
        tick();
        checkOutput("eb_head_pc", 64'(pcO), 64'h304);
        checkOutput("eb_hook_before", 64'(hookCnt), 64'd0);
        applyStimulus(1'b1, 32'h30c, 32'h0, 5'd5, 32'h3, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0);
        checkOutput("eb_halt", 64'(haltO), 64'd1);
        checkOutput("eb_count", 64'(countO), 64'd0);
        checkOutput("eb_ready", 64'(readyO), 64'd0);
        checkOutput("eb_valid", 64'(validO), 64'd0);
        checkOutput("eb_retire_cnt", retireCnt, 64'd2);
        checkOutput("eb_hook_once", 64'(hookCnt), 64'd1);
        flushIn = 1'b1;
        tick();
        flushIn = 1'b0;
        tick();
        checkOutput("eb_halt_sticky", 64'(haltO), 64'd1);
        checkOutput("eb_hook_still_once", 64'(hookCnt), 64'd1);
        checkOutput("eb_retire_cnt_frozen", retireCnt, 64'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checkOutput("eb_rst_halt", 64'(haltO), 64'd0);
        checkOutput("eb_rst_ready", 64'(readyO), 64'd1);
        checkOutput("eb_rst_retire_cnt", retireCnt, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
